// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the logic that drives it:
//   - opcode constants for the select input (N = 3 bits)
//   - scheduler state encoding
//   - helper to flag the reserved opcode
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_NOT = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_SLI = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  function automatic logic is_reserved(input logic [2:0] op);
    return op == OP_RSV;
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   valid0, valid1 : request lines
//   last_grant     : requester granted most recently (0 or 1)
//   grant0, grant1 : one-hot grant (both low when nobody requests)
// A lone requester always wins; on a tie the requester that did not win
// last time is granted.
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  assign grant0 = valid0 && (!valid1 || last_grant);
  assign grant1 = valid1 && (!valid0 || !last_grant);

endmodule

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
// Shares one registered ALU between two requesters. An op is taken on a
// valid/ready handshake (round-robin between the two sources), driven onto
// the ALU operand/select inputs, the ALU latency is waited out, and the
// result is returned with the owning requester id on one response channel.
// One op in flight at a time.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req{0,1}_valid/_ready           request handshake (ready only in IDLE)
//   req{0,1}_op/_a/_b               opcode and operands
//   rsp_valid/rsp_ready             response handshake
//   rsp_id/_data/_carry/_err        owner, captured R0, R0_carry, reserved op
//   alu_r2/alu_r3/alu_select        ALU drives, held until the next accept
//   alu_r0/alu_carry                ALU result inputs
//   busy                            high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for a request, grant and accept happen here
// EXEC  | ALU drives stable, counting out ALU_LAT+1 cycles
// RESP  | response presented, waiting for rsp_ready
// ---------------------------------------------------------------------------
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int SIZE    = 4,
  parameter int N       = 3,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [N-1:0]    req0_op,
  input  logic [SIZE-1:0] req0_a,
  input  logic [SIZE-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [N-1:0]    req1_op,
  input  logic [SIZE-1:0] req1_a,
  input  logic [SIZE-1:0] req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [SIZE-1:0] rsp_data,
  output logic            rsp_carry,
  output logic            rsp_err,
  output logic [SIZE-1:0] alu_r2,
  output logic [SIZE-1:0] alu_r3,
  output logic [N-1:0]    alu_select,
  input  logic [SIZE-1:0] alu_r0,
  input  logic            alu_carry,
  output logic            busy
);

  localparam int CW = 3;

  sched_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          last_grant_q;
  logic          id_q;
  logic          grant0, grant1;
  logic          accept, done;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == CW'(ALU_LAT)) begin
          done    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by rst_n so a requester holding valid through reset never
  // sees a handshake while the block is held in reset.
  assign req0_ready = rst_n && (state_q == IDLE) && grant0;
  assign req1_ready = rst_n && (state_q == IDLE) && grant1;
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      alu_r2       <= '0;
      alu_r3       <= '0;
      alu_select   <= '0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_carry    <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      if (accept) begin
        if (grant0) begin
          alu_select <= req0_op;
          alu_r2     <= req0_a;
          alu_r3     <= req0_b;
        end else begin
          alu_select <= req1_op;
          alu_r2     <= req1_a;
          alu_r3     <= req1_b;
        end
        id_q         <= grant1;
        last_grant_q <= grant1;
        cnt_q        <= '0;
      end else if (state_q == EXEC) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (done) begin
        rsp_data  <= alu_r0;
        rsp_carry <= alu_carry;
        rsp_err   <= is_reserved(3'(alu_select));
        rsp_id    <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   tests_run = 0;
  int   failed    = 0;

  // default build (ALU_LAT = 1)
  logic       r0v, r0r, r1v, r1r, rv, rr, rid, rc, re, busy;
  logic [2:0] r0op, r1op, sel;
  logic [3:0] r0a, r0b, r1a, r1b, rd, r2, r3, ar0;
  logic       ac;
  logic [4:0] alu_q;

  // ALU_LAT = 3 build
  logic       t_r0v, t_r0r, t_r1v, t_r1r, t_rv, t_rr, t_rid, t_rc, t_re, t_busy;
  logic [2:0] t_r0op, t_r1op, t_sel;
  logic [3:0] t_r0a, t_r0b, t_r1a, t_r1b, t_rd, t_r2, t_r3, t_ar0;
  logic       t_ac;
  logic [4:0] t_pipe [3];

  // Reference ALU: {carry, result}
  function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    logic [4:0] r;
    r = 5'd0;
    case (op)
      OP_MOV:  r = {1'b0, a};
      OP_NOT:  r = {1'b0, ~a};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_OR:   r = {1'b0, a | b};
      OP_AND:  r = {1'b0, a & b};
      OP_SLI:  r = {4'd0, ($signed(a) < $signed(b))};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) alu_q <= alu_f(sel, r2, r3);
  assign ar0 = alu_q[3:0];
  assign ac  = alu_q[4];

  always_ff @(posedge clk) begin
    t_pipe[0] <= alu_f(t_sel, t_r2, t_r3);
    t_pipe[1] <= t_pipe[0];
    t_pipe[2] <= t_pipe[1];
  end
  assign t_ar0 = t_pipe[2][3:0];
  assign t_ac  = t_pipe[2][4];

  alu_rr_scheduler #(.SIZE(4), .N(3), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(r0r), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(r1r), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid), .rsp_data(rd), .rsp_carry(rc),
    .rsp_err(re), .alu_r2(r2), .alu_r3(r3), .alu_select(sel), .alu_r0(ar0),
    .alu_carry(ac), .busy(busy)
  );

  alu_rr_scheduler #(.SIZE(4), .N(3), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(t_r0v), .req0_ready(t_r0r), .req0_op(t_r0op), .req0_a(t_r0a), .req0_b(t_r0b),
    .req1_valid(t_r1v), .req1_ready(t_r1r), .req1_op(t_r1op), .req1_a(t_r1a), .req1_b(t_r1b),
    .rsp_valid(t_rv), .rsp_ready(t_rr), .rsp_id(t_rid), .rsp_data(t_rd), .rsp_carry(t_rc),
    .rsp_err(t_re), .alu_r2(t_r2), .alu_r3(t_r3), .alu_select(t_sel), .alu_r0(t_ar0),
    .alu_carry(t_ac), .busy(t_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({r0r, r1r, rv, busy, rid, rc, re} !== 7'b0) begin
      failed++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {r0r, r1r, rv, busy, rid, rc, re});
    end
    tests_run++;
    if ({rd, r2, r3, sel} !== 15'd0) begin
      failed++;
      $display("FAIL reset_data: got %h expected 0", {rd, r2, r3, sel});
    end
    tests_run++;
    if ({t_r0r, t_r1r, t_rv, t_busy} !== 4'b0) begin
      failed++;
      $display("FAIL reset_lat3: got %b expected 0000", {t_r0r, t_r1r, t_rv, t_busy});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Edge count includes the accept edge: rsp_valid is seen after edge 3.
  task automatic test_single_op();
    int n;
    rr = 1'b0;
    r0v = 1'b1; r0op = OP_ADD; r0a = 4'd15; r0b = 4'd15;
    #1;
    tests_run++;
    if (r0r !== 1'b1 || r1r !== 1'b0) begin
      failed++;
      $display("FAIL single_ready: got r0=%b r1=%b expected r0=1 r1=0", r0r, r1r);
    end
    tick();
    r0v = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || r2 !== 4'd15 || r3 !== 4'd15 || sel !== OP_ADD) begin
      failed++;
      $display("FAIL single_drive: got busy=%b r2=%0d r3=%0d sel=%0d expected 1 15 15 2",
               busy, r2, r3, sel);
    end
    n = 1;
    while (!rv && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (n !== 3) begin
      failed++;
      $display("FAIL single_latency: got %0d edges expected 3", n);
    end
    tests_run++;
    if (rv !== 1'b1 || rd !== 4'd14 || rc !== 1'b1 || rid !== 1'b0 || re !== 1'b0) begin
      failed++;
      $display("FAIL single_rsp: got v=%b d=%0d c=%b id=%b e=%b expected 1 14 1 0 0",
               rv, rd, rc, rid, re);
    end
    rr = 1'b1;
    tick();
    tests_run++;
    if (rv !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL single_done: got v=%b busy=%b expected 0 0", rv, busy);
    end
  endtask

  task automatic test_simultaneous();
    logic       exp_id [4];
    logic [3:0] exp_d  [4];
    int         got;
    exp_id[0] = 1'b0; exp_d[0] = 4'd2;
    exp_id[1] = 1'b1; exp_d[1] = 4'd15;
    exp_id[2] = 1'b0; exp_d[2] = 4'd2;
    exp_id[3] = 1'b1; exp_d[3] = 4'd15;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rr  = 1'b1;
    r0v = 1'b1; r0op = OP_SUB; r0a = 4'd6;  r0b = 4'd4;
    r1v = 1'b1; r1op = OP_OR;  r1a = 4'd15; r1b = 4'd10;
    got = 0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      tick();
      if (rv) begin
        tests_run++;
        if (rid !== exp_id[got] || rd !== exp_d[got]) begin
          failed++;
          $display("FAIL simul_rsp%0d: got id=%b d=%0d expected id=%b d=%0d",
                   got, rid, rd, exp_id[got], exp_d[got]);
        end
        got++;
        if (got == 4) begin
          r0v = 1'b0;
          r1v = 1'b0;
        end
      end
    end
    r0v = 1'b0;
    r1v = 1'b0;
    tests_run++;
    if (got !== 4) begin
      failed++;
      $display("FAIL simul_count: got %0d responses expected 4", got);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    rr  = 1'b0;
    r0v = 1'b1; r0op = OP_AND; r0a = 4'd12; r0b = 4'd10;
    tick();
    r0v = 1'b0;
    n = 0;
    while (!rv && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (rv !== 1'b1) begin
      failed++;
      $display("FAIL bp_timeout: got rsp_valid=%b expected 1", rv);
    end
    r1v = 1'b1; r1op = OP_MOV; r1a = 4'd9; r1b = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (rv !== 1'b1 || rd !== 4'd8 || rid !== 1'b0 || rc !== 1'b0 || r1r !== 1'b0) begin
        failed++;
        $display("FAIL bp_hold%0d: got v=%b d=%0d id=%b c=%b r1r=%b expected 1 8 0 0 0",
                 i, rv, rd, rid, rc, r1r);
      end
    end
    rr = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || rv !== 1'b0 || r1r !== 1'b1) begin
      failed++;
      $display("FAIL bp_release: got busy=%b v=%b r1r=%b expected 0 0 1", busy, rv, r1r);
    end
    tick();
    r1v = 1'b0;
    n = 0;
    while (!rv && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (rv !== 1'b1 || rid !== 1'b1 || rd !== 4'd9) begin
      failed++;
      $display("FAIL bp_next: got v=%b id=%b d=%0d expected 1 1 9", rv, rid, rd);
    end
    tick();
  endtask

  task automatic test_reserved();
    int n;
    rr  = 1'b1;
    r1v = 1'b1; r1op = OP_RSV; r1a = 4'd3; r1b = 4'd3;
    tick();
    r1v = 1'b0;
    n = 0;
    while (!rv && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (rv !== 1'b1 || re !== 1'b1 || rid !== 1'b1) begin
      failed++;
      $display("FAIL rsv_rsp: got v=%b err=%b id=%b expected 1 1 1", rv, re, rid);
    end
    tick();
    r0v = 1'b1; r0op = OP_SLI; r0a = 4'hB; r0b = 4'hF;
    tick();
    r0v = 1'b0;
    n = 0;
    while (!rv && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (rv !== 1'b1 || re !== 1'b0 || rd !== 4'd1 || rid !== 1'b0) begin
      failed++;
      $display("FAIL sli_rsp: got v=%b err=%b d=%0d id=%b expected 1 0 1 0", rv, re, rd, rid);
    end
    tick();
  endtask

  task automatic test_reset_mid_exec();
    int seen;
    int n;
    rr  = 1'b1;
    r0v = 1'b1; r0op = OP_ADD; r0a = 4'd1; r0b = 4'd2;
    tick();
    r0v = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || rv !== 1'b0 || {r2, r3, sel} !== 11'd0) begin
      failed++;
      $display("FAIL rst_mid: got busy=%b v=%b drives=%h expected 0 0 0", busy, rv, {r2, r3, sel});
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rv) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      failed++;
      $display("FAIL rst_no_rsp: got %0d responses expected 0", seen);
    end
    r0v = 1'b1; r0op = OP_MOV; r0a = 4'd6; r0b = 4'd0;
    tick();
    r0v = 1'b0;
    n = 0;
    while (!rv && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (rv !== 1'b1 || rd !== 4'd6 || rid !== 1'b0) begin
      failed++;
      $display("FAIL rst_after: got v=%b d=%0d id=%b expected 1 6 0", rv, rd, rid);
    end
    tick();
  endtask

  // Edge count includes the accept edge: rsp_valid is seen after edge 5.
  task automatic test_lat3();
    int n;
    t_rr  = 1'b1;
    t_r0v = 1'b1; t_r0op = OP_NOT; t_r0a = 4'd5; t_r0b = 4'd0;
    #1;
    tests_run++;
    if (t_r0r !== 1'b1) begin
      failed++;
      $display("FAIL lat3_ready: got %b expected 1", t_r0r);
    end
    tick();
    t_r0v = 1'b0;
    n = 1;
    while (!t_rv && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (n !== 5) begin
      failed++;
      $display("FAIL lat3_latency: got %0d edges expected 5", n);
    end
    tests_run++;
    if (t_rv !== 1'b1 || t_rd !== 4'd10 || t_rid !== 1'b0) begin
      failed++;
      $display("FAIL lat3_rsp: got v=%b d=%0d id=%b expected 1 10 0", t_rv, t_rd, t_rid);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    r0v = 1'b0; r0op = '0; r0a = '0; r0b = '0;
    r1v = 1'b0; r1op = '0; r1a = '0; r1b = '0;
    rr  = 1'b0;
    t_r0v = 1'b0; t_r0op = '0; t_r0a = '0; t_r0b = '0;
    t_r1v = 1'b0; t_r1op = '0; t_r1a = '0; t_r1b = '0;
    t_rr  = 1'b0;
    tick();
    test_reset();
    test_single_op();
    test_simultaneous();
    test_backpressure();
    test_reserved();
    test_reset_mid_exec();
    test_lat3();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one registered ALU (`top`, opcodes MOV/NOT/ADD/SUB/OR/AND/SLI) between two requesters.
- Each requester hands over an operation on a valid/ready handshake. The block arbitrates round-robin, drives the ALU operand/select inputs, waits out the ALU latency, then returns the result with the requester id on a single response channel.
- Only one operation is in flight at a time.
- Sits between the two op sources and the ALU instance in the processor datapath.

Parameters:
- SIZE, 4, operand/result width (matches ALU size)
- N, 3, opcode width (matches ALU n)
- ALU_LAT, 1, ALU output register stages between operand change and valid R0 (1..7)

Ports:
- clk  in  1  rising-edge clock, shared with ALU
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_op  in  N  requester 0 opcode
- req0_a  in  SIZE  requester 0 operand A (to ALU R2)
- req0_b  in  SIZE  requester 0 operand B (to ALU R3)
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same widths/meaning for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that owns the result
- rsp_data  out  SIZE  captured ALU R0
- rsp_carry  out  1  captured ALU R0_carry
- rsp_err  out  1  opcode was reserved (7)
- alu_r2  out  SIZE  ALU R2 drive
- alu_r3  out  SIZE  ALU R3 drive
- alu_select  out  N  ALU select drive
- alu_r0  in  SIZE  ALU R0
- alu_carry  in  1  ALU R0_carry
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; all req*_ready=0; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_carry=0; rsp_err=0.
  - alu_r2=0; alu_r3=0; alu_select=0 (MOV); busy=0.
  - last_grant=1, so requester 0 wins the first tie.
- IDLE:
  - Grant is combinational. One valid wins alone. Both valid: the requester not equal to last_grant wins.
  - reqX_ready=1 only for the granted requester, only in IDLE; the handshake completes in that cycle.
  - On the accept edge: latch op/a/b into alu_select/alu_r2/alu_r3, latch id, update last_grant, set cnt=0, go EXEC.
  - Neither valid: stay in IDLE, all ready=0.
- EXEC:
  - ALU drives are held stable; cnt increments each cycle.
  - When cnt==ALU_LAT, on that edge capture rsp_data<=alu_r0, rsp_carry<=alu_carry, rsp_err<=(op==7), rsp_id<=id, then go RESP.
  - EXEC therefore lasts ALU_LAT+1 cycles.
  - Latency: rsp_valid rises ALU_LAT+2 edges after the accept edge (3 for the default).
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready=1.
  - When rsp_ready=1 on that edge: rsp_valid<=0, go IDLE.
  - No new accept occurs in RESP (all ready=0). Max throughput is one op per ALU_LAT+3 cycles.
- ALU drives are held after completion, not zeroed, until the next accept.
- Reserved opcode 7 is still issued to the ALU. The captured result is returned with rsp_err=1.
- Requests arriving while busy wait; valid must stay asserted, with no drop or reorder.
- Starvation-free: with both requesters held valid, grants strictly alternate 0,1,0,1.
- Reset mid-EXEC or mid-RESP: the op is discarded, no response is produced, and all outputs go to their reset values immediately.
- Arithmetic: no computation inside the block. Width rules are the ALU's; carry is passed through unchanged.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_MOV=0, OP_NOT=1, OP_ADD=2, OP_SUB=3, OP_OR=4, OP_AND=5, OP_SLI=6, OP_RSV=7
  - state encoding IDLE/EXEC/RESP
- One sub-module, rr_arb2: the 2-way round-robin arbiter (valid0, valid1, last_grant -> grant0, grant1).
- Counter and FSM stay in the top.

Test Plan:
- Single op, default params: req0 ADD a=15 b=15 -> req0_ready on accept cycle; rsp_valid 3 edges later; rsp_data=14, rsp_carry=1, rsp_id=0.
- Simultaneous requests from reset: req0 SUB a=6 b=4 and req1 OR a=15 b=10 held valid -> first response id=0 data=2, second id=1 data=15. Continuing to hold both valid gives alternating ids.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> data/id/carry stable; req1_valid held with ready=0; after rsp_ready=1, IDLE then accept of req1.
- Reserved op: req1 op=7 a=3 b=3 -> rsp_valid with rsp_err=1, rsp_id=1; next op SLI a=-5 b=-1 -> rsp_err=0, rsp_data=1.
- Reset mid-EXEC: assert rst_n=0 one cycle after accept -> outputs reset asynchronously, no rsp_valid ever for that op; after release, req0 MOV a=6 completes with data=6.
- ALU_LAT=3 build: NOT a=5 -> rsp_valid 5 edges after accept, data=10.
